// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit for the ID stage.
// Each read port is resolved on its own against the EXE, MEM and WB producers
// (youngest wins). A load in EXE feeding any enabled port starts a stall of
// exactly LOAD_LAT cycles. Operands, hit and source flags are registered and
// refreshed on every edge, stalled or not.
//
// Handshake: there is no valid/ready pair on this block. stall_o is a hold
// request; while it is high the upstream stages keep rd_en_i/rd_addr_i stable
// and present a bubble in EXE (exe_wena_i=0). The block never waits on upstream.
module fwd_hazard_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [NUM_RD-1:0]          rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    input  logic [NUM_RD*DATA_W-1:0]   rf_rdata_i,
    input  logic                       exe_wena_i,
    input  logic [ADDR_W-1:0]          exe_waddr_i,
    input  logic [DATA_W-1:0]          exe_wdata_i,
    input  logic                       exe_is_load_i,
    input  logic                       mem_wena_i,
    input  logic [ADDR_W-1:0]          mem_waddr_i,
    input  logic [DATA_W-1:0]          mem_wdata_i,
    input  logic                       wb_wena_i,
    input  logic [ADDR_W-1:0]          wb_waddr_i,
    input  logic [DATA_W-1:0]          wb_wdata_i,
    output logic [NUM_RD*DATA_W-1:0]   opnd_data_o,
    output logic [NUM_RD-1:0]          fwd_hit_o,
    output logic [NUM_RD*2-1:0]        fwd_src_o,
    output logic                       stall_o,
    output logic [CNT_W-1:0]           stall_count_o,
    output logic                       state_dbg_o
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    localparam logic [1:0] SRC_RF  = 2'd0;
    localparam logic [1:0] SRC_EXE = 2'd1;
    localparam logic [1:0] SRC_MEM = 2'd2;
    localparam logic [1:0] SRC_WB  = 2'd3;

    localparam logic [3:0] LAT_INIT = 4'(LOAD_LAT);

    state_e                     state_q;
    logic [3:0]                 lat_cnt_q;
    logic                       stall_q;
    logic [CNT_W-1:0]           stall_count_q;
    logic [NUM_RD*DATA_W-1:0]   opnd_q;
    logic [NUM_RD-1:0]          hit_q;
    logic [NUM_RD*2-1:0]        src_q;

    logic [NUM_RD*DATA_W-1:0]   opnd_d;
    logic [NUM_RD-1:0]          hit_d;
    logic [NUM_RD*2-1:0]        src_d;
    logic [NUM_RD-1:0]          port_haz;
    logic                       hazard;

    genvar g;
    for (g = 0; g < NUM_RD; g++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rf_data;
        logic              zero_blk;
        logic              m_exe;
        logic              m_mem;
        logic              m_wb;
        logic [DATA_W-1:0] p_data;
        logic              p_hit;
        logic [1:0]        p_src;

        assign addr     = rd_addr_i[g*ADDR_W +: ADDR_W];
        assign rf_data  = rf_rdata_i[g*DATA_W +: DATA_W];
        // Register 0 is hard-wired when ZERO_REG is set: it neither forwards nor stalls.
        assign zero_blk = (ZERO_REG != 0) && (addr == '0);
        assign m_exe    = exe_wena_i & rd_en_i[g] & (exe_waddr_i == addr) & ~zero_blk;
        assign m_mem    = mem_wena_i & rd_en_i[g] & (mem_waddr_i == addr) & ~zero_blk;
        assign m_wb     = wb_wena_i  & rd_en_i[g] & (wb_waddr_i  == addr) & ~zero_blk;
        assign port_haz[g] = m_exe & exe_is_load_i;

        // Select the youngest producer; a load in EXE passes the RF value until the load data arrives.
        always_comb begin
            p_data = rf_data;
            p_hit  = 1'b0;
            p_src  = SRC_RF;
            if (m_exe && exe_is_load_i) begin
                p_data = rf_data;
                p_hit  = 1'b0;
                p_src  = SRC_EXE;
            end else if (m_exe) begin
                p_data = exe_wdata_i;
                p_hit  = 1'b1;
                p_src  = SRC_EXE;
            end else if (m_mem) begin
                p_data = mem_wdata_i;
                p_hit  = 1'b1;
                p_src  = SRC_MEM;
            end else if (m_wb) begin
                p_data = wb_wdata_i;
                p_hit  = 1'b1;
                p_src  = SRC_WB;
            end
        end

        assign opnd_d[g*DATA_W +: DATA_W] = p_data;
        assign hit_d[g]                   = p_hit;
        assign src_d[g*2 +: 2]            = p_src;
    end

    assign hazard = |port_haz;

    // Operand registers, saturating stall counter and the RUN/STALL controller.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= ST_RUN;
            lat_cnt_q     <= '0;
            stall_q       <= 1'b0;
            stall_count_q <= '0;
            opnd_q        <= '0;
            hit_q         <= '0;
            src_q         <= '0;
        end else begin
            opnd_q <= opnd_d;
            hit_q  <= hit_d;
            src_q  <= src_d;

            if (stall_q && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end

            case (state_q)
                ST_RUN: begin
                    if (!flush_i && hazard) begin
                        state_q   <= ST_STALL;
                        stall_q   <= 1'b1;
                        lat_cnt_q <= LAT_INIT;
                    end
                end
                ST_STALL: begin
                    if (flush_i) begin
                        state_q   <= ST_RUN;
                        stall_q   <= 1'b0;
                        lat_cnt_q <= '0;
                    end else if (lat_cnt_q == 4'd1) begin
                        // Last stalled edge: a fresh hazard here chains straight into another stall.
                        if (hazard) begin
                            state_q   <= ST_STALL;
                            stall_q   <= 1'b1;
                            lat_cnt_q <= LAT_INIT;
                        end else begin
                            state_q   <= ST_RUN;
                            stall_q   <= 1'b0;
                            lat_cnt_q <= '0;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q   <= ST_RUN;
                    stall_q   <= 1'b0;
                    lat_cnt_q <= '0;
                end
            endcase
        end
    end

    assign opnd_data_o   = opnd_q;
    assign fwd_hit_o     = hit_q;
    assign fwd_src_o     = src_q;
    assign stall_o       = stall_q;
    assign stall_count_o = stall_count_q;
    assign state_dbg_o   = state_q;

endmodule
